// File: rtl/bru_pkg.sv
// Shared constants for the execute-stage branch resolver.
// Func codes, the BRANCH op class and the BHT counter helpers.
package bru_pkg;

   localparam logic [3:0] OP_BRANCH = 4'b0010;

   localparam logic [3:0] BRU_BT    = 4'd0;
   localparam logic [3:0] BRU_BNEZ  = 4'd1;
   localparam logic [3:0] BRU_BEQZ  = 4'd2;
   localparam logic [3:0] BRU_BF    = 4'd3;
   localparam logic [3:0] BRU_BNE   = 4'd5;
   localparam logic [3:0] BRU_BEQ   = 4'd6;
   localparam logic [3:0] BRU_BLTEZ = 4'd8;
   localparam logic [3:0] BRU_BLT   = 4'd9;
   localparam logic [3:0] BRU_BGTE  = 4'd10;
   localparam logic [3:0] BRU_BGT   = 4'd11;
   localparam logic [3:0] BRU_BLTE  = 4'd12;
   localparam logic [3:0] BRU_BLTZ  = 4'd13;
   localparam logic [3:0] BRU_BGTEZ = 4'd14;
   localparam logic [3:0] BRU_BGTZ  = 4'd15;

   // Weakly not-taken
   localparam logic [1:0] BHT_RST = 2'b01;

   function automatic logic [1:0] bht_next(
      input logic [1:0] ctr,
      input logic       tk
   );
      logic [1:0] nxt;
      nxt = ctr;
      if (tk && ctr != 2'b11)
         nxt = ctr + 2'd1;
      else if (!tk && ctr != 2'b00)
         nxt = ctr - 2'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/bru_bht.sv
// Branch history table: 2-bit saturating counters.
// Lookup is combinational and sees the pre-update value.
module bru_bht
   import bru_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] lkp_idx,
   output logic [1:0]       lkp_ctr,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   logic [1:0] ctr [DEPTH];

   assign lkp_ctr = ctr[lkp_idx];

   // Reset every counter to weak NT; train one entry per update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            ctr[i] <= BHT_RST;
      end else if (upd_en) begin
         ctr[upd_idx] <= bht_next(ctr[upd_idx], upd_taken);
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver with a one-deep output register.
// Define BRU_STATS_EN to add branch / mispredict counters.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 16,
   parameter int BHT_DEPTH = 16,
   parameter int PC_INC    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        opcode,
   input  logic [3:0]        func,
   input  logic [DATA_W-1:0] src_data0,
   input  logic [DATA_W-1:0] src_data1,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] target,
   input  logic              pred_taken,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              is_branch,
   output logic              taken,
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_pc,
   input  logic [ADDR_W-1:0] lkp_pc,
   output logic              lkp_pred
`ifdef BRU_STATS_EN
   ,
   output logic [31:0]       stat_branches,
   output logic [31:0]       stat_mispred
`endif
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic              accept;
   logic              upd_en;
   logic              br_next;
   logic              tk_next;
   logic              mp_next;
   logic [ADDR_W-1:0] rpc_next;
   logic [IDX_W-1:0]  res_idx;
   logic [1:0]        lkp_ctr;
   logic              unused_lkp;

   function automatic logic cond(
      input logic [3:0]               f,
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      logic z;
      logic n;
      logic r;
      z = (a == '0);
      n = a[DATA_W-1];
      case (f)
         BRU_BT:    r = 1'b1;
         BRU_BF:    r = 1'b0;
         BRU_BEQ:   r = (a == b);
         BRU_BNE:   r = (a != b);
         BRU_BLT:   r = (a < b);
         BRU_BGTE:  r = (a >= b);
         BRU_BLTE:  r = (a <= b);
         BRU_BGT:   r = (a > b);
         BRU_BEQZ:  r = z;
         BRU_BNEZ:  r = !z;
         BRU_BLTZ:  r = n;
         BRU_BGTEZ: r = !n;
         BRU_BLTEZ: r = n | z;
         BRU_BGTZ:  r = !n & !z;
         default:   r = 1'b0;
      endcase
      return r;
   endfunction

   assign in_ready   = !out_valid | out_ready;
   assign accept     = in_valid & in_ready & !flush;
   assign upd_en     = out_valid & out_ready & is_branch & !flush;
   assign lkp_pred   = lkp_ctr[1];
   assign unused_lkp = ^lkp_pc[ADDR_W-1:IDX_W];

   // Resolve the incoming op ahead of the output register
   always_comb begin
      br_next  = (opcode == OP_BRANCH);
      tk_next  = br_next & cond(func, src_data0, src_data1);
      mp_next  = br_next & (tk_next != pred_taken);
      rpc_next = tk_next ? target : pc + ADDR_W'(PC_INC);
   end

   // Output register: load on accept, drain on handshake, kill on flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         is_branch   <= 1'b0;
         taken       <= 1'b0;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
         res_idx     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         is_branch   <= br_next;
         taken       <= tk_next;
         mispredict  <= mp_next;
         redirect_pc <= rpc_next;
         res_idx     <= pc[IDX_W-1:0];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   bru_bht #(
      .DEPTH (BHT_DEPTH)
   ) u_bht (
      .clk       (clk),
      .rst_n     (rst_n),
      .lkp_idx   (lkp_pc[IDX_W-1:0]),
      .lkp_ctr   (lkp_ctr),
      .upd_en    (upd_en),
      .upd_idx   (res_idx),
      .upd_taken (taken)
   );

`ifdef BRU_STATS_EN
   // Saturating counts of retired branches and their mispredicts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else if (upd_en) begin
         if (stat_branches != '1)
            stat_branches <= stat_branches + 32'd1;
         if (mispredict && stat_mispred != '1)
            stat_mispred <= stat_mispred + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit.
// Table vectors, corner sequences and a randomized model comparison.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic [3:0]  func;
   logic [31:0] src_data0;
   logic [31:0] src_data1;
   logic [15:0] pc;
   logic [15:0] target;
   logic        pred_taken;
   logic        out_valid;
   logic        out_ready;
   logic        is_branch;
   logic        taken;
   logic        mispredict;
   logic [15:0] redirect_pc;
   logic [15:0] lkp_pc;
   logic        lkp_pred;
`ifdef BRU_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispred;
`endif

   branch_resolve_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opcode      (opcode),
      .func        (func),
      .src_data0   (src_data0),
      .src_data1   (src_data1),
      .pc          (pc),
      .target      (target),
      .pred_taken  (pred_taken),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .is_branch   (is_branch),
      .taken       (taken),
      .mispredict  (mispredict),
      .redirect_pc (redirect_pc),
      .lkp_pc      (lkp_pc),
      .lkp_pred    (lkp_pred)
`ifdef BRU_STATS_EN
      ,
      .stat_branches (stat_branches),
      .stat_mispred  (stat_mispred)
`endif
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // reference model state
   bit     mv, mbr, mtk, mmp;
   int     mrpc, midx;
   int     mbht [16];
   longint mst_b, mst_m;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   function automatic bit m_eval(input int f, input int a, input int b);
      case (f)
         0:  return 1;
         3:  return 0;
         6:  return a == b;
         5:  return a != b;
         9:  return a < b;
         10: return a >= b;
         12: return a <= b;
         11: return a > b;
         2:  return a == 0;
         1:  return a != 0;
         13: return a < 0;
         14: return a >= 0;
         8:  return a <= 0;
         15: return a > 0;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      mv = 0; mbr = 0; mtk = 0; mmp = 0; mrpc = 0; midx = 0;
      foreach (mbht[i]) mbht[i] = 1;
      mst_b = 0; mst_m = 0;
   endtask

   // One clock: drive at negedge, check comb outputs, advance, check regs
   task automatic step(input bit iv, input int op, input int fn,
                       input int a, input int b, input bit pt,
                       input int p, input int t, input bit ordy,
                       input bit fl, input int lpc);
      bit hs, acc;
      in_valid   = iv;
      opcode     = op[3:0];
      func       = fn[3:0];
      src_data0  = a;
      src_data1  = b;
      pred_taken = pt;
      pc         = p[15:0];
      target     = t[15:0];
      out_ready  = ordy;
      flush      = fl;
      lkp_pc     = lpc[15:0];
      #1;
      chk("in_ready", in_ready, !mv || ordy);
      chk("lkp_pred", lkp_pred, mbht[lpc % 16] >= 2);
      hs  = mv && ordy && !fl;
      acc = iv && (!mv || ordy) && !fl;
      if (hs && mbr) begin
         if (mtk && mbht[midx] < 3) mbht[midx]++;
         if (!mtk && mbht[midx] > 0) mbht[midx]--;
         mst_b++;
         if (mmp) mst_m++;
      end
      if (acc) begin
         mv   = 1;
         mbr  = (op == 2);
         mtk  = mbr && m_eval(fn, a, b);
         mmp  = mbr && (mtk != pt);
         mrpc = mtk ? t : (p + 1) % 65536;
         midx = p % 16;
      end else if (fl || ordy) begin
         mv = 0;
      end
      @(posedge clk);
      @(negedge clk);
      chk("out_valid", out_valid, mv);
      if (mv) begin
         chk("is_branch", is_branch, mbr);
         chk("taken", taken, mtk);
         chk("mispredict", mispredict, mmp);
         chk("redirect_pc", redirect_pc, mrpc);
      end
`ifdef BRU_STATS_EN
      chk("stat_branches", stat_branches, mst_b);
      chk("stat_mispred", stat_mispred, mst_m);
`endif
   endtask

   task automatic idle(input int lpc);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, lpc);
   endtask

   typedef struct {
      int op; int fn; int a; int b; bit pt; int pc; int tg;
      bit e_br; bit e_tk; bit e_mp; int e_rpc;
   } vec_t;

   vec_t tbl [9];
   int   pool [6];

   initial begin
      tbl[0] = '{2, 9, -1, 1, 0, 5, 'h100, 1, 1, 1, 'h100};
      tbl[1] = '{2, 15, int'(32'h8000_0000), 0, 1, 6, 'h200, 1, 0, 1, 7};
      tbl[2] = '{2, 1, 0, 5, 0, 8, 'h300, 1, 0, 0, 9};
      tbl[3] = '{2, 0, 3, 4, 1, 9, 'h400, 1, 1, 0, 'h400};
      tbl[4] = '{2, 4, 1, 1, 0, 11, 'h500, 1, 0, 0, 12};
      tbl[5] = '{2, 5, 7, 7, 0, 'hFFFF, 'h10, 1, 0, 0, 0};
      tbl[6] = '{1, 0, 0, 0, 1, 12, 'h600, 0, 0, 0, 13};
      tbl[7] = '{2, 10, -5, -5, 1, 13, 'h700, 1, 1, 0, 'h700};
      tbl[8] = '{2, 8, 0, 0, 0, 14, 'h800, 1, 1, 1, 'h800};

      rst_n = 0; flush = 0; in_valid = 0; opcode = 0; func = 0;
      src_data0 = 0; src_data1 = 0; pc = 0; target = 0;
      pred_taken = 0; out_ready = 0; lkp_pc = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_is_branch", is_branch, 0);
      chk("rst_taken", taken, 0);
      chk("rst_mispredict", mispredict, 0);
      chk("rst_redirect", redirect_pc, 0);
      chk("rst_lkp_pred", lkp_pred, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // table vectors, back-to-back
      foreach (tbl[i]) begin
         step(1, tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].pt,
              tbl[i].pc, tbl[i].tg, 1, 0, 5);
         chk($sformatf("tbl%0d_br", i), is_branch, tbl[i].e_br);
         chk($sformatf("tbl%0d_tk", i), taken, tbl[i].e_tk);
         chk($sformatf("tbl%0d_mp", i), mispredict, tbl[i].e_mp);
         chk($sformatf("tbl%0d_rpc", i), redirect_pc, tbl[i].e_rpc);
      end
      idle(5);
      #1;
      chk("bht_blt_trained", lkp_pred, 1);

      // stall: result held while a new op waits
      step(1, 2, 9, 1, 2, 0, 3, 'h33, 1, 0, 3);
      for (int k = 0; k < 3; k++) begin
         step(1, 2, 0, 0, 0, 0, 4, 'h44, 0, 0, 3);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_valid", out_valid, 1);
         chk("stall_rpc", redirect_pc, 'h33);
         chk("stall_no_upd", lkp_pred, 0);
      end
      step(1, 2, 0, 0, 0, 0, 4, 'h44, 1, 0, 3);
      chk("stall_next_rpc", redirect_pc, 'h44);
      idle(3);
      #1;
      chk("stall_upd", lkp_pred, 1);

      // counter saturation at one PC (index 10)
      for (int k = 0; k < 4; k++)
         step(1, 2, 0, 0, 0, 1, 'h2A, 'h99, 1, 0, 'h2A);
      idle('h2A);
      #1;
      chk("sat_taken_pred", lkp_pred, 1);
      step(1, 2, 3, 0, 0, 1, 'h2A, 'h99, 1, 0, 'h2A);
      step(1, 2, 3, 0, 0, 1, 'h2A, 'h99, 1, 0, 'h2A);
      #1;
      chk("nt1_pred", lkp_pred, 1);
      idle('h2A);
      #1;
      chk("nt2_pred", lkp_pred, 0);

      // flush with a concurrent input
      step(1, 2, 0, 0, 0, 0, 'h2A, 'h99, 1, 1, 'h2A);
      chk("flush_valid", out_valid, 0);
      idle('h2A);
      #1;
      chk("flush_no_upd", lkp_pred, 0);

      // reset pulse during a stall
      step(1, 2, 0, 0, 0, 0, 1, 'h11, 1, 0, 5);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
      rst_n = 0;
      #1;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_bht", lkp_pred, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

`ifdef BRU_STATS_EN
      step(1, 2, 0, 0, 0, 1, 20, 'h5, 1, 0, 0);
      step(1, 2, 3, 0, 0, 0, 21, 'h5, 1, 0, 0);
      step(1, 2, 0, 0, 0, 0, 22, 'h5, 1, 0, 0);
      idle(0);
      chk("stat_b3", stat_branches, 3);
      chk("stat_m1", stat_mispred, 1);
`endif

      // randomized traffic against the model
      pool[0] = 0; pool[1] = 1; pool[2] = -1;
      pool[3] = int'(32'h8000_0000); pool[4] = 32'h7fff_ffff;
      for (int k = 0; k < 500; k++) begin
         int a, b, op;
         pool[5] = int'($urandom);
         a  = pool[$urandom_range(0, 5)];
         b  = ($urandom_range(0, 3) == 0) ? a : pool[$urandom_range(0, 5)];
         op = ($urandom_range(0, 9) < 7) ? 2 : int'($urandom_range(0, 15));
         step($urandom_range(0, 3) != 0, op, $urandom_range(0, 15), a, b,
              $urandom_range(0, 1) == 1, $urandom_range(0, 65535),
              $urandom_range(0, 65535), $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) == 0, $urandom_range(0, 65535));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
